// File: rtl/pixel_scan_sequencer.sv
// Raster-order pixel/sample coordinate generator feeding the ray generator.
// Walks every pixel SAMPLES_PER_PIXEL times, honours stall, and pulses frame_done at frame end.
module pixel_scan_sequencer #(
  parameter int PIXEL_WIDTH       = 800,
  parameter int PIXEL_HEIGHT      = 600,
  parameter int SAMPLES_PER_PIXEL = 4,
  parameter int COORD_W           = 10,
  parameter int SAMPLE_W          = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                stall,
  output logic [COORD_W-1:0]  pixel_x,
  output logic [COORD_W-1:0]  pixel_y,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic                pixel_valid,
  output logic                last_sample,
  output logic                busy,
  output logic                frame_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COORD_W-1:0]  X_LAST = COORD_W'(PIXEL_WIDTH - 1);
  localparam logic [COORD_W-1:0]  Y_LAST = COORD_W'(PIXEL_HEIGHT - 1);
  localparam logic [SAMPLE_W-1:0] S_LAST = SAMPLE_W'(SAMPLES_PER_PIXEL - 1);
  localparam logic [COORD_W-1:0]  C_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0]  C_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic [SAMPLE_W-1:0] S_ZERO = {SAMPLE_W{1'b0}};
  localparam logic [SAMPLE_W-1:0] S_ONE  = {{(SAMPLE_W-1){1'b0}}, 1'b1};

  state_t                state_r;
  state_t                next_state_s;
  logic [COORD_W-1:0]    x_next_s;
  logic [COORD_W-1:0]    y_next_s;
  logic [SAMPLE_W-1:0]   s_next_s;
  logic                  valid_next_s;
  logic                  last_next_s;
  logic                  busy_next_s;
  logic                  done_next_s;
  logic                  accept_s;

  assign accept_s = pixel_valid && !stall;

  // Next-state and next-output computation; outputs are registered from these.
  always_comb begin
    next_state_s = state_r;
    x_next_s     = pixel_x;
    y_next_s     = pixel_y;
    s_next_s     = sample_idx;
    valid_next_s = pixel_valid;
    busy_next_s  = busy;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        x_next_s     = C_ZERO;
        y_next_s     = C_ZERO;
        s_next_s     = S_ZERO;
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
        if (frame_start) begin
          next_state_s = SCAN;
          valid_next_s = 1'b1;
          busy_next_s  = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SCAN: begin
        if (accept_s) begin
          if (last_sample) begin
            next_state_s = DONE;
            x_next_s     = C_ZERO;
            y_next_s     = C_ZERO;
            s_next_s     = S_ZERO;
            valid_next_s = 1'b0;
            busy_next_s  = 1'b1;
            done_next_s  = 1'b1;
          end else if (sample_idx == S_LAST) begin
            // Sample wrap carries into the column, column wrap into the row.
            s_next_s = S_ZERO;
            if (pixel_x == X_LAST) begin
              x_next_s = C_ZERO;
              y_next_s = pixel_y + C_ONE;
            end else begin
              x_next_s = pixel_x + C_ONE;
            end
          end else begin
            s_next_s = sample_idx + S_ONE;
          end
        end else begin
          next_state_s = SCAN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
        x_next_s     = C_ZERO;
        y_next_s     = C_ZERO;
        s_next_s     = S_ZERO;
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
      end
      default: begin
        next_state_s = IDLE;
        x_next_s     = C_ZERO;
        y_next_s     = C_ZERO;
        s_next_s     = S_ZERO;
        valid_next_s = 1'b0;
        busy_next_s  = 1'b0;
      end
    endcase
    last_next_s = valid_next_s && (x_next_s == X_LAST) && (y_next_s == Y_LAST) &&
                  (s_next_s == S_LAST);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pixel_x     <= C_ZERO;
      pixel_y     <= C_ZERO;
      sample_idx  <= S_ZERO;
      pixel_valid <= 1'b0;
      last_sample <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      pixel_x     <= x_next_s;
      pixel_y     <= y_next_s;
      sample_idx  <= s_next_s;
      pixel_valid <= valid_next_s;
      last_sample <= last_next_s;
      busy        <= busy_next_s;
      frame_done  <= done_next_s;
    end
  end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Directed bench for pixel_scan_sequencer: vector table plus hand-written frame sequences.
// Main instance uses W=4,H=3,SPP=2; a second instance uses SPP=1 for the row-wrap case.
module tb_pixel_scan_sequencer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int SPP = 2;
  localparam int NS  = W * H * SPP;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       frame_start1;
  logic       stall;

  logic [9:0] px, py, px1, py1;
  logic [3:0] si, si1;
  logic       pv, ls, bz, fd;
  logic       pv1, ls1, bz1, fd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pixel_scan_sequencer #(
    .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .SAMPLES_PER_PIXEL(SPP), .COORD_W(10), .SAMPLE_W(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .stall(stall),
    .pixel_x(px), .pixel_y(py), .sample_idx(si), .pixel_valid(pv),
    .last_sample(ls), .busy(bz), .frame_done(fd)
  );

  pixel_scan_sequencer #(
    .PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .SAMPLES_PER_PIXEL(1), .COORD_W(10), .SAMPLE_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start1), .stall(stall),
    .pixel_x(px1), .pixel_y(py1), .sample_idx(si1), .pixel_valid(pv1),
    .last_sample(ls1), .busy(bz1), .frame_done(fd1)
  );

  typedef struct {
    logic        rst;
    logic        fs;
    logic        stall;
    logic [27:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [27:0] pk(input int x, input int y, input int s,
                                     input logic v, input logic l, input logic b, input logic d);
    logic [9:0] xx;
    logic [9:0] yy;
    logic [3:0] ss;
    xx = 10'(x);
    yy = 10'(y);
    ss = 4'(s);
    return {xx, yy, ss, v, l, b, d};
  endfunction

  function automatic logic [27:0] frame_exp(input int k);
    return pk((k / SPP) % W, k / (SPP * W), k % SPP, 1'b1, (k == NS - 1), 1'b1, 1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d s=%0d v=%b l=%b b=%b d=%b, expected x=%0d y=%0d s=%0d v=%b l=%b b=%b d=%b",
               name, got[27:18], got[17:8], got[7:4], got[3], got[2], got[1], got[0],
               exp[27:18], exp[17:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [27:0] outs();
    return {px, py, si, pv, ls, bz, fd};
  endfunction

  function automatic logic [27:0] outs1();
    return {px1, py1, si1, pv1, ls1, bz1, fd1};
  endfunction

  // Runs one frame on the SPP=2 instance with optional stalls, an ignored frame_start, or a reset.
  task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                           input int final_stall, input int fs_at, input int rst_at);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      chk($sformatf("%s_k%0d", tag, k), outs(), frame_exp(k));
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk($sformatf("%s_rst", tag), outs(), pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        step();
        chk($sformatf("%s_rst_nodone", tag), outs(), pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        return;
      end
      if (k == stall_at || (k == NS - 1 && final_stall > 0)) begin
        stall = 1'b1;
        for (int j = 0; j < ((k == stall_at) ? stall_len : final_stall); j++) begin
          step();
          chk($sformatf("%s_hold_k%0d_c%0d", tag, k, j), outs(), frame_exp(k));
        end
        stall = 1'b0;
      end
      if (k == fs_at) frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    chk($sformatf("%s_done", tag), outs(), pk(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk($sformatf("%s_idle", tag), outs(), pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    rst          = 1'b1;
    frame_start  = 1'b0;
    frame_start1 = 1'b0;
    stall        = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, pk(0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0)};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, pk(0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, pk(0, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0)};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, pk(1, 0, 1, 1'b1, 1'b0, 1'b1, 1'b0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};
    tbl[11] = '{1'b0, 1'b0, 1'b0, pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0)};

    for (int i = 0; i < 12; i++) begin
      rst         = tbl[i].rst;
      frame_start = tbl[i].fs;
      stall       = tbl[i].stall;
      step();
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    frame_start = 1'b0;
    stall       = 1'b0;

    for (int i = 0; i < 8; i++) begin
      stall = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("idle_rand%0d", i), outs(), pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    stall = 1'b0;

    run_frame("full", -1, 0, 0, 7, -1);
    run_frame("stall", 13, 5, 3, -1, -1);
    run_frame("midrst", -1, 0, 0, -1, 18);
    run_frame("restart", -1, 0, 0, -1, -1);

    frame_start1 = 1'b1;
    step();
    frame_start1 = 1'b0;
    for (int k = 0; k < W * H; k++) begin
      chk($sformatf("spp1_k%0d", k), outs1(),
          pk(k % W, k / W, 0, 1'b1, (k == W * H - 1), 1'b1, 1'b0));
      step();
    end
    chk("spp1_done", outs1(), pk(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1));
    step();
    chk("spp1_idle", outs1(), pk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
